// File: rtl/imm_decode_pkg.sv
// Shared definitions for the immediate-decode front stage.
//   - RV32I opcode constants
//   - immediate format select codes (imm_sel_t)
//   - skid-buffer occupancy state encodings (occ_state_t)
//   - per-entry storage layout (entry_t)
//   - gen_imm(): builds the sign/zero-extended immediate for a format
package imm_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_U     = 3'b000,
    IMM_J     = 3'b001,
    IMM_I     = 3'b010,
    IMM_B     = 3'b011,
    IMM_S     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_NONE  = 3'b111
  } imm_sel_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_sel_t    sel;
    logic [31:0] target;
    logic        illegal;
  } entry_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_sel_t sel);
    logic [31:0] imm;
    imm = 32'h0;
    case (sel)
      IMM_U:     imm = {ins[31:12], 12'b0};
      IMM_J:     imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_I:     imm = {{20{ins[31]}}, ins[31:20]};
      IMM_B:     imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_S:     imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      // Shift amount only; funct7 (ins[31:25]) selects SRLI/SRAI elsewhere.
      IMM_SHAMT: imm = {27'b0, ins[24:20]};
      default:   imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/imm_decode_stage_imm_type_decoder.sv
// imm_type_decoder: combinational classification of an RV32I opcode.
// Ports:
//   opcode    - instruction bits [6:0]
//   funct3    - instruction bits [14:12] (splits OP-IMM shifts from I-type)
//   sel       - immediate format code
//   illegal   - opcode is not part of RV32I
//   target_en - PC-relative target applies (JAL, branches, AUIPC)
module imm_type_decoder
  import imm_decode_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output imm_sel_t   sel,
  output logic       illegal,
  output logic       target_en
);

  always_comb begin
    sel       = IMM_NONE;
    illegal   = 1'b0;
    target_en = 1'b0;
    case (opcode)
      OPC_LUI:   sel = IMM_U;
      OPC_AUIPC: begin
        sel       = IMM_U;
        target_en = 1'b1;
      end
      OPC_JAL: begin
        sel       = IMM_J;
        target_en = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: sel = IMM_I;
      OPC_OP_IMM: begin
        // SLLI / SRLI / SRAI carry a shift amount instead of a 12-bit immediate.
        if (funct3 == 3'b001 || funct3 == 3'b101) sel = IMM_SHAMT;
        else                                      sel = IMM_I;
      end
      OPC_BRANCH: begin
        sel       = IMM_B;
        target_en = 1'b1;
      end
      OPC_STORE: sel = IMM_S;
      // Register-register ops are legal but have no immediate.
      OPC_OP:    sel = IMM_NONE;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decode front stage between IF and EX.
// Captures instructions over a valid/ready handshake, decodes the immediate
// format, immediate and PC-relative target at capture time, and holds up to
// two decoded entries in a FIFO-ordered skid buffer.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   in_valid/in_ready          - upstream handshake (in_ready registered)
//   in_instruction, in_pc      - fetched instruction and its PC
//   flush                      - synchronous kill of all held entries
//   out_valid/out_ready        - downstream handshake
//   out_instruction, out_pc    - head entry instruction and PC
//   out_imm, out_imm_sel       - decoded immediate and its format code
//   out_target                 - in_pc + imm for J/B/AUIPC, else RESET_PC_TARGET
//   out_illegal                - head opcode is not RV32I
//   dbg_state                  - occupancy FSM state (EMPTY/ONE/TWO)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Ready never depends combinationally on valid on either side.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int          XLEN            = 32,
  parameter logic [31:0] RESET_PC_TARGET = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instruction,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_sel,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic [1:0]      dbg_state
);

  occ_state_t state_q, state_d;
  entry_t     head_q, tail_q;
  entry_t     new_entry;
  logic       in_ready_q;
  logic       acc, pop;

  imm_sel_t   dec_sel;
  logic       dec_illegal;
  logic       dec_target_en;

  imm_type_decoder u_type_dec (
    .opcode    (in_instruction[6:0]),
    .funct3    (in_instruction[14:12]),
    .sel       (dec_sel),
    .illegal   (dec_illegal),
    .target_en (dec_target_en)
  );

  // Decoded form of the presented instruction; stored as-is on capture.
  always_comb begin
    new_entry         = '0;
    new_entry.instr   = in_instruction;
    new_entry.pc      = in_pc;
    new_entry.sel     = dec_sel;
    new_entry.imm     = gen_imm(in_instruction, dec_sel);
    new_entry.illegal = dec_illegal;
    // Adder wraps modulo 2^32.
    new_entry.target  = dec_target_en ? (in_pc + new_entry.imm) : RESET_PC_TARGET;
  end

  assign acc = in_valid & in_ready_q;
  assign pop = out_valid & out_ready;

  // State register; in_ready is registered from the next state so it never
  // needs a combinational path from out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != OCC_TWO);
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (acc) state_d = OCC_ONE;
        OCC_ONE: begin
          if (acc && !pop)      state_d = OCC_TWO;
          else if (!acc && pop) state_d = OCC_EMPTY;
        end
        OCC_TWO:   if (pop) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // Entry storage: head_q is always the oldest entry, tail_q the second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      case (state_q)
        OCC_EMPTY: if (acc) head_q <= new_entry;
        OCC_ONE: begin
          if (acc && pop) head_q <= new_entry;
          else if (acc)   tail_q <= new_entry;
        end
        OCC_TWO:   if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    in_ready        = in_ready_q;
    out_valid       = (state_q != OCC_EMPTY);
    out_instruction = head_q.instr;
    out_pc          = head_q.pc;
    out_imm         = head_q.imm;
    out_imm_sel     = head_q.sel;
    out_target      = head_q.target;
    out_illegal     = head_q.illegal;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  localparam int EW = 132;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_sel;
  logic [31:0] out_target;
  logic        out_illegal;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .RESET_PC_TARGET(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_imm         (out_imm),
    .out_imm_sel     (out_imm_sel),
    .out_target      (out_target),
    .out_illegal     (out_illegal),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] imm, input logic [2:0] sel,
                                       input logic [31:0] tgt, input logic ill);
    return {ins, pc, imm, sel, tgt, ill};
  endfunction

  function automatic logic [EW-1:0] head_obs();
    return {out_instruction, out_pc, out_imm, out_imm_sel, out_target, out_illegal};
  endfunction

  // Monitor: every transfer out of the stage must match the oldest expected
  // entry. A flush drops whatever remains after this cycle's transfer.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_out: observed %0h expected none", head_obs());
      end
      if (exp_q.size() > 0) chk("out_entry", head_obs(), exp_q.pop_front());
    end
    if (flush) exp_q.delete();
  end

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted; the expected entry
  // is pushed once acceptance at the coming edge is certain.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [2:0] sel,
                      input logic [31:0] tgt, input logic ill);
    int budget;
    in_valid       = 1'b1;
    in_instruction = ins;
    in_pc          = pc;
    budget         = 20;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    assert (budget > 0) else begin
      fails++;
      $error("FAIL accept_timeout: observed in_ready=%0b expected 1", in_ready);
    end
    if (budget > 0) exp_q.push_back(mk(ins, pc, imm, sel, tgt, ill));
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_instruction = '0;
    in_pc          = '0;
    flush          = 1'b0;
    out_ready      = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset_outputs", {in_ready, out_valid, head_obs(), dbg_state}, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    chk("idle_state", dbg_state, 0);

    // LUI with one-cycle latency from an empty stage.
    step();
    send(32'h123450B7, 32'h0000_0100, 32'h1234_5000, 3'b000, 32'h0, 1'b0);
    @(negedge clk);
    chk("lui_latency_valid", out_valid, 1);

    // Back-to-back stream with EX always ready.
    step();
    send(32'hFFDFF06F, 32'h0000_1000, 32'hFFFF_FFFC, 3'b001, 32'h0000_0FFC, 1'b0); // JAL
    send(32'h00000463, 32'hFFFF_FFFC, 32'h0000_0008, 3'b011, 32'h0000_0004, 1'b0); // BEQ wrap
    send(32'h4030D093, 32'h0000_0200, 32'h0000_0003, 3'b101, 32'h0, 1'b0);         // SRAI
    send(32'h0020A423, 32'h0000_0204, 32'h0000_0008, 3'b100, 32'h0, 1'b0);         // SW
    send(32'h0000007F, 32'h0000_0208, 32'h0,         3'b111, 32'h0, 1'b1);         // illegal
    send(32'h00001017, 32'h0000_0300, 32'h0000_1000, 3'b000, 32'h0000_1300, 1'b0); // AUIPC
    send(32'h002081B3, 32'h0000_0304, 32'h0,         3'b111, 32'h0, 1'b0);         // ADD
    send(32'h00008067, 32'h0000_0308, 32'h0,         3'b010, 32'h0, 1'b0);         // JALR
    send(32'h0040A103, 32'h0000_030C, 32'h0000_0004, 3'b010, 32'h0, 1'b0);         // LW
    repeat (3) step();
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure: two accepted, third held, then all drain in order.
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h0000_0400, 32'hFFFF_FFFF, 3'b010, 32'h0, 1'b0);         // ADDI -1
    send(32'hFE001EE3, 32'h0000_2000, 32'hFFFF_FFFC, 3'b011, 32'h0000_1FFC, 1'b0); // BNE -4
    @(negedge clk);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_state_two", dbg_state, 2);
    step();
    in_valid       = 1'b1;
    in_instruction = 32'h00001017;
    in_pc          = 32'h0000_0500;
    @(negedge clk);
    chk("bp_third_held", in_ready, 0);
    chk("bp_head_first", out_instruction, 32'hFFF00093);
    step();
    out_ready = 1'b1;
    send(32'h00001017, 32'h0000_0500, 32'h0000_1000, 3'b000, 32'h0000_1500, 1'b0);
    repeat (3) step();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_empty_state", dbg_state, 0);

    // Flush while holding two entries with a new instruction presented.
    out_ready = 1'b0;
    send(32'h00100093, 32'h0000_0600, 32'h0000_0001, 3'b010, 32'h0, 1'b0);
    send(32'h00200113, 32'h0000_0604, 32'h0000_0002, 3'b010, 32'h0, 1'b0);
    in_valid       = 1'b1;
    in_instruction = 32'h00300193;
    in_pc          = 32'h0000_0608;
    flush          = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid_low", out_valid, 0);
    chk("flush_ready_high", in_ready, 1);
    step();
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_nothing_left", out_valid, 0);

    // Flush in ONE with a pop and a presented instruction in the same cycle:
    // the head is consumed, the presented one is dropped.
    out_ready = 1'b0;
    send(32'h00400213, 32'h0000_0700, 32'h0000_0004, 3'b010, 32'h0, 1'b0);
    out_ready      = 1'b1;
    in_valid       = 1'b1;
    in_instruction = 32'h00500293;
    in_pc          = 32'h0000_0704;
    flush          = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pop_valid_low", out_valid, 0);
    repeat (3) step();
    chk("flush_pop_drained", exp_q.size(), 0);

    // Asynchronous reset while holding two entries.
    out_ready = 1'b0;
    send(32'h00600313, 32'h0000_0800, 32'h0000_0006, 3'b010, 32'h0, 1'b0);
    send(32'h00700393, 32'h0000_0804, 32'h0000_0007, 3'b010, 32'h0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", {in_ready, out_valid, head_obs(), dbg_state}, '0);
    exp_q.delete();
    repeat (2) step();
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("rst2_ready_after_edge", in_ready, 1);

    // Stage works again after reset.
    step();
    send(32'h123450B7, 32'h0000_0900, 32'h1234_5000, 3'b000, 32'h0, 1'b0);
    repeat (3) step();
    chk("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
